// File: rtl/alu_result_tx_pkg.sv
// Shared types and helpers for the ALU result serialiser.
package alu_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    function automatic int unsigned num_bytes(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// Valid/ready handshake carrying one ALU result and its opcode.
interface alu_result_tx_if #(
    parameter int unsigned NUM_WIDTH    = 8,
    parameter int unsigned OPCODE_WIDTH = 4
) ();
    logic                    valid;
    logic                    ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [NUM_WIDTH-1:0]    answer;

    modport master (output valid, output opcode, output answer, input ready);
    modport slave  (input valid, input opcode, input answer, output ready);
endinterface

// File: rtl/alu_result_tx_uart_tx_byte.sv
// 8N1 serialiser for one byte; a load on the final stop cycle chains the next byte with no gap.
module uart_tx_byte
    import alu_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy_c,
    output logic       last_c
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        last_c  = 1'b0;
        bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = data;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    last_c = 1'b1;
                    if (load) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = data;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx     = tx_q;
    assign busy_c = (state_q != IDLE);

endmodule

// File: rtl/alu_result_tx.sv
// Captures an ALU result plus opcode and sends {A,opcode} then the result bytes LSB first over 8N1.
module alu_result_tx
    import alu_tx_pkg::*;
#(
    parameter int unsigned num_width    = 8,
    parameter int unsigned opcode_width = 4,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset,
    alu_result_tx_if.slave in_if,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    localparam int unsigned NUM_BYTES = num_bytes(num_width);
    localparam int unsigned BUF_W     = NUM_BYTES * 8;
    localparam int unsigned BCNT_W    = $clog2(NUM_BYTES + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("alu_result_tx: CLKS_PER_BIT must be at least 2");
    end
    if (num_width < 1 || num_width > 32) begin : g_bad_num_width
        $error("alu_result_tx: num_width must be in 1..32");
    end
    if (opcode_width < 1 || opcode_width > 4) begin : g_bad_opcode_width
        $error("alu_result_tx: opcode_width must be in 1..4");
    end

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              accept_c;
    logic              load_c;
    logic [7:0]        load_byte_c;
    logic              byte_busy_c;
    logic              byte_last_c;

    // Byte sequencing: header on accept, then one buffered result byte per completed byte.
    always_comb begin
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        buf_d       = buf_q;
        bcnt_d      = bcnt_q;
        load_c      = 1'b0;
        load_byte_c = '0;
        accept_c    = in_if.valid && ready_q && !byte_busy_c;

        if (accept_c) begin
            load_c      = 1'b1;
            load_byte_c = {SYNC_NIBBLE, 4'(in_if.opcode)};
            buf_d       = BUF_W'(in_if.answer);
            bcnt_d      = '0;
            ready_d     = 1'b0;
            busy_d      = 1'b1;
        end else if (byte_last_c) begin
            if (bcnt_q == BCNT_W'(NUM_BYTES)) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                load_c      = 1'b1;
                load_byte_c = buf_q[7:0];
                buf_d       = buf_q >> 8;
                bcnt_d      = bcnt_q + BCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            buf_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            buf_q   <= buf_d;
            bcnt_q  <= bcnt_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .data   (load_byte_c),
        .tx     (tx),
        .busy_c (byte_busy_c),
        .last_c (byte_last_c)
    );

    assign in_if.ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Two lanes (8-bit result/4-bit opcode and 12-bit result/3-bit opcode) checked by a line-decoding scoreboard.
module tb_alu_result_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_byte_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       valid_a [2];
    logic [3:0] opc_a   [2];
    logic [11:0] ans_a  [2];
    logic       ready_a [2];
    logic       tx_a    [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic       tx0, tx1, busy0, busy1, done0, done1;

    exp_byte_t  exb [2][$];
    int         exd [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_result_tx_if #(.NUM_WIDTH(8),  .OPCODE_WIDTH(4)) if0 ();
    alu_result_tx_if #(.NUM_WIDTH(12), .OPCODE_WIDTH(3)) if1 ();

    assign if0.valid  = valid_a[0];
    assign if0.opcode = opc_a[0];
    assign if0.answer = ans_a[0][7:0];
    assign if1.valid  = valid_a[1];
    assign if1.opcode = opc_a[1][2:0];
    assign if1.answer = ans_a[1];
    assign ready_a[0] = if0.ready;
    assign ready_a[1] = if1.ready;
    assign tx_a[0] = tx0;    assign tx_a[1] = tx1;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1;
    assign done_a[0] = done0; assign done_a[1] = done1;

    alu_result_tx #(.num_width(8), .opcode_width(4), .CLKS_PER_BIT(CPB)) dut0 (
        .clk(clk), .reset(rst), .in_if(if0.slave), .tx(tx0), .busy(busy0), .done(done0));
    alu_result_tx #(.num_width(12), .opcode_width(3), .CLKS_PER_BIT(CPB)) dut1 (
        .clk(clk), .reset(rst), .in_if(if1.slave), .tx(tx1), .busy(busy1), .done(done1));

    function automatic int lane_nw(input int l);
        return (l == 0) ? 8 : 12;
    endfunction

    function automatic int lane_ow(input int l);
        return (l == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: header {A, opcode}, then the masked result little-endian.
    task automatic push_frame(input int l, input logic [3:0] o, input logic [11:0] a, input int acc);
        int nw = lane_nw(l);
        int nb = (nw + 7) / 8;
        int val = int'(a) & ((1 << nw) - 1);
        int hdr = 32'hA0 | (int'(o) & ((1 << lane_ow(l)) - 1));
        exp_byte_t e;
        e.b = hdr[7:0];
        e.t = acc;
        exb[l].push_back(e);
        for (int j = 1; j <= nb; j++) begin
            int bv = (val >> (8 * (j - 1))) & 32'hFF;
            e.b = bv[7:0];
            e.t = acc + j * 10 * CPB;
            exb[l].push_back(e);
        end
        exd[l].push_back(acc + (nb + 1) * 10 * CPB);
    endtask

    task automatic offer(input int l, input logic [3:0] o, input logic [11:0] a, output int acc);
        int budget = 400;
        @(negedge clk);
        valid_a[l] = 1'b1;
        opc_a[l]   = o;
        ans_a[l]   = a;
        while (!(ready_a[l] === 1'b1 && !rst) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout lane%0d: ready never rose, required ready=1", l);
            valid_a[l] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        push_frame(l, o, a, acc);
        @(posedge clk);
    endtask

    task automatic idle_lane(input int l);
        @(negedge clk);
        valid_a[l] = 1'b0;
    endtask

    task automatic wait_idle(input int l);
        int budget = 2000;
        while ((exb[l].size() != 0 || exd[l].size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout lane%0d: %0d bytes pending, required 0", l, exb[l].size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_lane(input int l);
        int acc;
        logic [31:0] r;
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            offer(l, r[3:0], r[15:4], acc);
            if ($urandom_range(0, 2) != 0) begin
                idle_lane(l);
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
        end
        idle_lane(l);
        wait_idle(l);
    endtask

    // Line decoders: every bit is sampled on each of its cycles, so length and level are both checked.
    for (genvar L = 0; L < 2; L++) begin : g_mon
        initial begin : byte_mon
            logic [7:0] got;
            logic       level;
            int         st;
            bit         ok;
            bit         abort;
            exp_byte_t  e;
            forever begin
                @(negedge clk);
                if (!rst && tx_a[L] === 1'b0) begin
                    st = cyc; ok = 1'b1; abort = 1'b0; got = '0; level = 1'b0;
                    for (int i = 0; i < 10 * CPB; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst) begin
                            abort = 1'b1;
                            break;
                        end
                        if (i % CPB == 0) level = tx_a[L];
                        else if (tx_a[L] !== level) ok = 1'b0;
                        if (i / CPB == 0 && tx_a[L] !== 1'b0) ok = 1'b0;
                        if (i / CPB == 9 && tx_a[L] !== 1'b1) ok = 1'b0;
                        if (i / CPB >= 1 && i / CPB <= 8 && i % CPB == 0) got[i / CPB - 1] = tx_a[L];
                    end
                    if (!abort) begin
                        checks++;
                        if (exb[L].size() == 0) begin
                            errors++;
                            $display("FAIL byte lane%0d: got %02h at cycle %0d, required no byte", L, got, st);
                        end else begin
                            e = exb[L].pop_front();
                            if (got !== e.b || st != e.t || !ok) begin
                                errors++;
                                $display("FAIL byte lane%0d: got %02h at cycle %0d shape_ok=%0d, required %02h at cycle %0d",
                                         L, got, st, ok, e.b, e.t);
                            end
                        end
                    end
                end
            end
        end

        initial begin : done_mon
            int t;
            forever begin
                @(negedge clk);
                if (!rst && done_a[L] === 1'b1) begin
                    checks++;
                    if (exd[L].size() == 0) begin
                        errors++;
                        $display("FAIL done lane%0d: pulse at cycle %0d, required none", L, cyc);
                    end else begin
                        t = exd[L].pop_front();
                        if (cyc != t) begin
                            errors++;
                            $display("FAIL done lane%0d: pulse at cycle %0d, required cycle %0d", L, cyc, t);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a1, a2, acc;
        bit seen;
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            valid_a[l] = 1'b1;
            opc_a[l]   = 4'h0;
            ans_a[l]   = 12'h000;
        end

        // Reset dominates a held valid.
        repeat (3) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                chk("reset_tx", 32'(tx_a[l]), 1);
                chk("reset_ready", 32'(ready_a[l]), 1);
                chk("reset_busy", 32'(busy_a[l]), 0);
                chk("reset_done", 32'(done_a[l]), 0);
            end
        end
        rst = 1'b0;
        valid_a[0] = 1'b0;
        valid_a[1] = 1'b0;
        @(negedge clk);
        chk("post_reset_busy0", 32'(busy_a[0]), 0);
        chk("post_reset_busy1", 32'(busy_a[1]), 0);

        offer(0, 4'h3, 12'h05A, acc); idle_lane(0); wait_idle(0);
        offer(1, 4'h1, 12'hABC, acc); idle_lane(1); wait_idle(1);

        // valid held across two frames.
        offer(0, 4'h9, 12'h011, a1);
        offer(0, 4'hC, 12'h022, a2);
        idle_lane(0);
        chk("b2b_gap", 32'(a2 - a1), 32'(10 * CPB * 2 + 1));
        wait_idle(0);

        // Offers while busy are dropped and ready stays low until done.
        offer(0, 4'h6, 12'h044, acc); idle_lane(0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_a[0] = 1'b1;
            ans_a[0]   = 12'h0FF;
            chk("busy_ready", 32'(ready_a[0]), 0);
        end
        @(negedge clk);
        valid_a[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done_a[0] === 1'b1) begin
                seen = 1'b1;
                chk("ready_at_done", 32'(ready_a[0]), 1);
            end else begin
                chk("ready_until_done", 32'(ready_a[0]), 0);
            end
        end
        chk("done_seen", 32'(seen), 1);
        wait_idle(0);

        // Reset 30 cycles into a frame truncates it with no done.
        offer(1, 4'h5, 12'h123, acc); idle_lane(1);
        while (cyc < acc + 29) @(negedge clk);
        rst = 1'b1;
        exb[1].delete();
        exd[1].delete();
        @(negedge clk);
        chk("midreset_tx", 32'(tx_a[1]), 1);
        chk("midreset_busy", 32'(busy_a[1]), 0);
        chk("midreset_ready", 32'(ready_a[1]), 1);
        chk("midreset_done", 32'(done_a[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        offer(1, 4'(($urandom_range(0, 7))), 12'h077, acc); idle_lane(1); wait_idle(1);

        fork
            rand_lane(0);
            rand_lane(1);
        join

        for (int l = 0; l < 2; l++) begin
            chk("bytes_left", 32'(exb[l].size()), 0);
            chk("dones_left", 32'(exd[l].size()), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
